// File: rtl/conv_channel_accum.sv
// Channel accumulator: sums NUM_CH partial sums, adds bias, rounds/rescales, activates, handshakes one pixel out.
// Optional ReLU activation enabled by defining CONV_RELU_EN; default build saturates to a signed OUT_W result.
module conv_channel_accum #(
    parameter int IN_W   = 21,
    parameter int NUM_CH = 8,
    parameter int ACC_W  = 26,
    parameter int BIAS_W = 16,
    parameter int SHIFT  = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   partial_sum,
    input  logic              sum_valid,
    input  logic [BIAS_W-1:0] bias,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  result,
    output logic              result_valid,
    output logic              busy,
    output logic              drop
);

    localparam int CW = $clog2(NUM_CH + 1);
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(64'sd1 <<< (SHIFT - 1));
`ifdef CONV_RELU_EN
    localparam logic signed [ACC_W:0] UMAX = (ACC_W+1)'((64'sd1 <<< OUT_W) - 64'sd1);
`else
    localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SMIN = (ACC_W+1)'(-(64'sd1 <<< (OUT_W - 1)));
`endif

    typedef enum logic [2:0] {IDLE, ACCUM, BIAS, SCALE, OUT} state_t;

    state_t                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CW-1:0]            cnt_q;
    logic [OUT_W-1:0]         result_q;
    logic                     result_valid_q;
    logic                     drop_q;

    logic signed [ACC_W-1:0]  ps_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W:0]    scaled_d;
    logic [OUT_W-1:0]         sat_d;
    logic                     busy_d;

    // Round half up, then floor via arithmetic shift; one guard bit keeps the rounding add from wrapping.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + RND;
        return s >>> SHIFT;
    endfunction

    function automatic logic [OUT_W-1:0] saturate(input logic signed [ACC_W:0] t);
`ifdef CONV_RELU_EN
        if (t < 0)
            return '0;
        else if (t > UMAX)
            return '1;
        else
            return t[OUT_W-1:0];
`else
        if (t > SMAX)
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (t < SMIN)
            return {1'b1, {(OUT_W-1){1'b0}}};
        else
            return t[OUT_W-1:0];
`endif
    endfunction

    assign ps_ext   = {{(ACC_W-IN_W){partial_sum[IN_W-1]}}, partial_sum};
    assign bias_ext = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
    assign scaled_d = round_shift(acc_q);
    assign sat_d    = saturate(scaled_d);
    assign busy_d   = (state_q == BIAS) || (state_q == SCALE) || (state_q == OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            // Sums arriving while the pixel is being finished are discarded and flagged.
            drop_q <= sum_valid && busy_d;
            case (state_q)
                IDLE: begin
                    if (sum_valid) begin
                        acc_q   <= ps_ext;
                        cnt_q   <= CW'(1);
                        state_q <= (NUM_CH == 1) ? BIAS : ACCUM;
                    end
                end
                ACCUM: begin
                    if (sum_valid) begin
                        acc_q <= acc_q + ps_ext;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(NUM_CH - 1))
                            state_q <= BIAS;
                    end
                end
                BIAS: begin
                    acc_q   <= acc_q + bias_ext;
                    state_q <= SCALE;
                end
                SCALE: begin
                    result_q       <= sat_d;
                    result_valid_q <= 1'b1;
                    state_q        <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        result_valid_q <= 1'b0;
                        cnt_q          <= '0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_d;
    assign drop         = drop_q;

endmodule

// File: tb/tb_conv_channel_accum.sv
// Randomized self-checking bench for conv_channel_accum against an arithmetic reference model.
// Define CONV_RELU_EN for both bench and RTL to exercise the ReLU build.
module tb_conv_channel_accum;

    localparam int IN_W   = 21;
    localparam int NUM_CH = 8;
    localparam int ACC_W  = 26;
    localparam int BIAS_W = 16;
    localparam int SHIFT  = 8;
    localparam int OUT_W  = 8;

    logic              clk;
    logic              rst;
    logic [IN_W-1:0]   partial_sum;
    logic              sum_valid;
    logic [BIAS_W-1:0] bias;
    logic              out_ready;
    logic [OUT_W-1:0]  result;
    logic              result_valid;
    logic              busy;
    logic              drop;

    int checks   = 0;
    int failures = 0;

    conv_channel_accum #(
        .IN_W(IN_W), .NUM_CH(NUM_CH), .ACC_W(ACC_W),
        .BIAS_W(BIAS_W), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .partial_sum(partial_sum),
        .sum_valid(sum_valid),
        .bias(bias),
        .out_ready(out_ready),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
        .drop(drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer math, floor division, then clamp to the output range.
    function automatic longint model(input longint total, input longint b);
        longint n, d, q, lim;
        d = longint'(1) <<< SHIFT;
        n = total + b + (d / 2);
        q = n / d;
        if ((n % d) != 0 && n < 0)
            q = q - 1;
`ifdef CONV_RELU_EN
        lim = (longint'(1) <<< OUT_W) - 1;
        if (q < 0) q = 0;
        else if (q > lim) q = lim;
`else
        lim = longint'(1) <<< (OUT_W - 1);
        if (q > lim - 1) q = lim - 1;
        else if (q < -lim) q = -lim;
`endif
        return q & ((longint'(1) <<< OUT_W) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " result"}, result, 0);
        check_eq({tag, " valid"}, result_valid, 0);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " drop"}, drop, 0);
    endtask

    // mode 0: every sum equals fixedv; mode 1: uniform random in [-rng, rng].
    task automatic run_pixel(input string tag, input int mode, input longint fixedv,
                             input longint rng, input longint b, input int maxgap,
                             input int stall, input bit drops);
        longint total, v, expv, junk;
        int gap;
        bit pulse;
        total = 0;
        bias = b[BIAS_W-1:0];
        out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0;
            repeat (gap) begin
                sum_valid = 1'b0;
                tick();
            end
            v = (mode != 0) ? (longint'($urandom_range(0, 32'(2 * rng))) - rng) : fixedv;
            partial_sum = v[IN_W-1:0];
            sum_valid = 1'b1;
            total += v;
            tick();
        end
        sum_valid = 1'b0;
        expv = model(total, b);
        check_eq({tag, " busy_after_last"}, busy, 1);
        tick();
        check_eq({tag, " not_yet_valid"}, result_valid, 0);
        tick();
        check_eq({tag, " valid"}, result_valid, 1);
        check_eq({tag, " result"}, result, expv);
        if (stall > 0) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                pulse = drops && (s == 1 || s == 3);
                junk = longint'($urandom_range(0, 2000)) - 1000;
                partial_sum = junk[IN_W-1:0];
                sum_valid = pulse;
                tick();
                check_eq({tag, " drop"}, drop, longint'(pulse));
                check_eq({tag, " held_result"}, result, expv);
                check_eq({tag, " held_valid"}, result_valid, 1);
                check_eq({tag, " held_busy"}, busy, 1);
            end
            sum_valid = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check_eq({tag, " accepted_valid"}, result_valid, 0);
        check_eq({tag, " accepted_busy"}, busy, 0);
    endtask

    initial begin
        longint rng, b;
        int stall;
        rst = 1'b1;
        sum_valid = 1'b0;
        partial_sum = '0;
        bias = '0;
        out_ready = 1'b0;
        tick();
        sum_valid = 1'b1;
        partial_sum = IN_W'(1000);
        tick();
        check_idle_outputs("reset");
        sum_valid = 1'b0;
        rst = 1'b0;
        tick();

        run_pixel("pos1000", 0, 1000, 0, 0, 0, 0, 1'b0);
        run_pixel("neg500", 0, -500, 0, 0, 0, 0, 1'b0);
        run_pixel("big", 0, 100000, 0, 0, 0, 0, 1'b0);
        run_pixel("gaps", 0, 256, 0, 256, 3, 0, 1'b0);
        run_pixel("stall", 0, 1000, 0, 0, 0, 5, 1'b1);
        run_pixel("after_drop", 0, 256, 0, 256, 0, 0, 1'b0);

        // Abort a pixel after three sums; the next pixel must start clean.
        bias = BIAS_W'(256);
        partial_sum = IN_W'(256);
        sum_valid = 1'b1;
        repeat (3) tick();
        sum_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        run_pixel("post_rst", 0, 256, 0, 256, 0, 0, 1'b0);

        for (int p = 0; p < 25; p++) begin
            case ($urandom_range(0, 2))
                0: rng = 300;
                1: rng = 8000;
                default: rng = (longint'(1) <<< (IN_W - 1)) - 1;
            endcase
            b = longint'($urandom_range(0, 65534)) - 32767;
            stall = int'($urandom_range(0, 5));
            run_pixel("rand", 1, 0, rng, b, int'($urandom_range(0, 2)), stall, stall == 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_channel_accum.md
# conv_channel_accum

Downstream of the three-input adder stage: accumulates NUM_CH successive signed partial sums (one per input channel) into a wide accumulator, adds a per-filter bias, then rescales with rounding, applies activation/saturation and presents one output pixel with a valid/ready handshake. Its sum input connects directly to the adder stage's registered sum and `done` outputs.

## Interface
- IN_W, 21, width of signed partial sum from the adder stage
- NUM_CH, 8, partial sums accumulated per output pixel (≥1)
- ACC_W, 26, signed accumulator width; must be ≥ IN_W + clog2(NUM_CH) + 1
- BIAS_W, 16, signed bias width (≤ ACC_W)
- SHIFT, 8, right-shift applied after bias (≥1)
- OUT_W, 8, output pixel width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- partial_sum  in  IN_W  signed partial sum (adder stage output)
- sum_valid  in  1  partial_sum valid this cycle (adder stage `done`)
- bias  in  BIAS_W  signed bias; must be stable from first sum until result_valid
- out_ready  in  1  consumer accepts result
- result  out  OUT_W  activated, saturated pixel
- result_valid  out  1  result valid; held until accepted
- busy  out  1  block cannot accept partial sums
- drop  out  1  one-cycle pulse: sum_valid arrived while busy (sum discarded)

## Operation
- States: IDLE, ACCUM, BIAS, SCALE, OUT. busy = state ∈ {BIAS, SCALE, OUT}.
- IDLE: on sum_valid, acc ← sext(partial_sum), cnt ← 1; → ACCUM (or → BIAS directly if NUM_CH=1).
- ACCUM: on sum_valid, acc ← acc + sext(partial_sum), cnt ← cnt+1; when the accepted sum is the NUM_CH-th → BIAS. Cycles without sum_valid hold state; gaps of any length allowed.
- BIAS: acc ← acc + sext(bias); → SCALE.
- SCALE: t = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic, floor); activation/saturation (see Configuration); result ← value, result_valid ← 1; → OUT.
- OUT: hold result/result_valid; when result_valid && out_ready at a clock edge → IDLE, result_valid ← 0, cnt ← 0.
- sum_valid while busy: sum not accumulated, drop ← 1 for the following cycle; otherwise drop ← 0.
- Accumulator cannot overflow given the ACC_W rule; no wrap handling.

## Timing
- Reset values: result=0, result_valid=0, busy=0, drop=0; acc=0, cnt=0, state=IDLE.
- Reset mid-operation (any state) discards the partial accumulation and any held result in the same edge.
- Latency: edge k captures the NUM_CH-th sum → BIAS; edge k+1 adds bias; edge k+2 result_valid=1. busy high from after edge k until the acceptance edge.
- Acceptance edge returns to IDLE; the earliest next sum is accepted on the following edge (one bubble per pixel).
- out_ready may be held high continuously; out_ready while result_valid=0 has no effect.
- rst has priority over all other inputs.

## Configuration
- CONV_RELU_EN defined: ReLU; t<0 → 0; t>2^OUT_W−1 → 2^OUT_W−1; result is unsigned.
- CONV_RELU_EN undefined: no activation; result is signed, saturated to [−2^(OUT_W−1), 2^(OUT_W−1)−1].

## Test plan
- Eight sums of 1000, bias 0, out_ready=1 → result_valid 2 cycles after last sum, result=31 (either config).
- Eight sums of −500, bias 0 → with CONV_RELU_EN result=0; without, result=−16 (0xF0).
- Eight sums of 100000, bias 0 → with CONV_RELU_EN result=255; without, result=127.
- Sums of 256 with 1–3 idle cycles between, bias 256 → result=9; cnt counts only valid cycles.
- Hold out_ready=0 for 5 cycles after result_valid, pulse sum_valid twice → result stable, busy=1, drop pulses twice, next pixel unaffected by dropped sums.
- Assert rst after 3 of 8 sums → all outputs 0 next cycle; following 8 sums of 256 with bias 256 → result=9.
